// File: rtl/zap_regf_write_queue.sv
// Write-side front end of the flip-flop register file.
// ALU (A) and load (B) writebacks merge into an in-order queue. The queue drains
// up to two entries per cycle onto the dual write ports, which share one enable.
// A combinational lookup over the queued and staged writes serves the issue stage.
module zap_regf_write_queue #(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 40
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_a_valid,
    output logic                     o_a_ready,
    input  logic [ADDR_W-1:0]        i_a_addr,
    input  logic [DATA_W-1:0]        i_a_data,
    input  logic                     i_b_valid,
    output logic                     o_b_ready,
    input  logic [ADDR_W-1:0]        i_b_addr,
    input  logic [DATA_W-1:0]        i_b_data,
    input  logic                     i_hold,
    output logic                     o_wen,
    output logic [ADDR_W-1:0]        o_wr_addr_a,
    output logic [ADDR_W-1:0]        o_wr_addr_b,
    output logic [DATA_W-1:0]        o_wr_data_a,
    output logic [DATA_W-1:0]        o_wr_data_b,
    input  logic [ADDR_W-1:0]        i_rd_addr_a,
    input  logic [ADDR_W-1:0]        i_rd_addr_b,
    input  logic [ADDR_W-1:0]        i_rd_addr_c,
    input  logic [ADDR_W-1:0]        i_rd_addr_d,
    output logic [3:0]               o_pending,
    output logic [DATA_W-1:0]        o_fwd_data_a,
    output logic [DATA_W-1:0]        o_fwd_data_b,
    output logic [DATA_W-1:0]        o_fwd_data_c,
    output logic [DATA_W-1:0]        o_fwd_data_d,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] wr_addr_a_q, wr_addr_a_d, wr_addr_b_q, wr_addr_b_d;
    logic [DATA_W-1:0] wr_data_a_q, wr_data_a_d, wr_data_b_q, wr_data_b_d;

    logic [CNT_W-1:0]  free_slots;
    logic              enq_a, enq_b;
    logic [1:0]        n_pop;
    logic [PTR_W-1:0]  wr_ptr_b, rd_ptr_nx;

    logic [ADDR_W-1:0] rd_addr  [4];
    logic [DATA_W-1:0] fwd_data [4];

    // Ready looks only at the registered count, so a same-cycle drain gives no credit.
    always_comb begin
        free_slots = CNT_W'(DEPTH) - count_q;
        o_a_ready  = free_slots >= CNT_W'(1);
        o_b_ready  = free_slots >= (i_a_valid ? CNT_W'(2) : CNT_W'(1));
        enq_a      = i_a_valid & o_a_ready;
        enq_b      = i_b_valid & o_b_ready;
    end

    // Enqueue (A before B), pop up to two oldest entries, and stage them for the write ports.
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        wr_ptr_b = wr_ptr_q + PTR_W'(enq_a);
        if (enq_a) begin
            addr_d[wr_ptr_q] = i_a_addr;
            data_d[wr_ptr_q] = i_a_data;
        end
        if (enq_b) begin
            addr_d[wr_ptr_b] = i_b_addr;
            data_d[wr_ptr_b] = i_b_data;
        end
        wr_ptr_d = wr_ptr_b + PTR_W'(enq_b);

        if (i_hold || count_q == '0) begin
            n_pop = 2'd0;
        end else if (count_q == CNT_W'(1)) begin
            n_pop = 2'd1;
        end else begin
            n_pop = 2'd2;
        end
        rd_ptr_nx = rd_ptr_q + PTR_W'(1);
        rd_ptr_d  = rd_ptr_q + PTR_W'(n_pop);
        count_d   = count_q + CNT_W'(enq_a) + CNT_W'(enq_b) - CNT_W'(n_pop);

        wen_d       = n_pop != 2'd0;
        wr_addr_a_d = wr_addr_a_q;
        wr_data_a_d = wr_data_a_q;
        wr_addr_b_d = wr_addr_b_q;
        wr_data_b_d = wr_data_b_q;
        if (n_pop != 2'd0) begin
            // A single pop is mirrored onto _b so the shared-enable dual write is harmless.
            wr_addr_a_d = addr_q[rd_ptr_q];
            wr_data_a_d = data_q[rd_ptr_q];
            wr_addr_b_d = (n_pop == 2'd2) ? addr_q[rd_ptr_nx] : addr_q[rd_ptr_q];
            wr_data_b_d = (n_pop == 2'd2) ? data_q[rd_ptr_nx] : data_q[rd_ptr_q];
        end
    end

    // Control and staged-output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            wen_q       <= 1'b0;
            wr_addr_a_q <= '0;
            wr_addr_b_q <= '0;
            wr_data_a_q <= '0;
            wr_data_b_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            wen_q       <= wen_d;
            wr_addr_a_q <= wr_addr_a_d;
            wr_addr_b_q <= wr_addr_b_d;
            wr_data_a_q <= wr_data_a_d;
            wr_data_b_q <= wr_data_b_d;
        end
    end

    // Queue storage; contents are meaningless outside the count window, so no reset.
    always_ff @(posedge i_clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    // Pending/forward lookup, scanned oldest to youngest so the youngest match wins.
    always_comb begin
        rd_addr[0] = i_rd_addr_a;
        rd_addr[1] = i_rd_addr_b;
        rd_addr[2] = i_rd_addr_c;
        rd_addr[3] = i_rd_addr_d;
        for (int k = 0; k < 4; k++) begin
            o_pending[k] = 1'b0;
            fwd_data[k]  = '0;
            if (wen_q && wr_addr_a_q == rd_addr[k]) begin
                o_pending[k] = 1'b1;
                fwd_data[k]  = wr_data_a_q;
            end
            if (wen_q && wr_addr_b_q == rd_addr[k]) begin
                o_pending[k] = 1'b1;
                fwd_data[k]  = wr_data_b_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) < count_q &&
                    addr_q[rd_ptr_q + PTR_W'(i)] == rd_addr[k]) begin
                    o_pending[k] = 1'b1;
                    fwd_data[k]  = data_q[rd_ptr_q + PTR_W'(i)];
                end
            end
        end
    end

    assign o_fwd_data_a = fwd_data[0];
    assign o_fwd_data_b = fwd_data[1];
    assign o_fwd_data_c = fwd_data[2];
    assign o_fwd_data_d = fwd_data[3];
    assign o_wen        = wen_q;
    assign o_wr_addr_a  = wr_addr_a_q;
    assign o_wr_addr_b  = wr_addr_b_q;
    assign o_wr_data_a  = wr_data_a_q;
    assign o_wr_data_b  = wr_data_b_q;
    assign o_count      = count_q;

    a_addr_legal: assert property (@(posedge i_clk) disable iff (i_reset)
        i_a_valid |-> 32'(i_a_addr) < NUM_REGS);
    b_addr_legal: assert property (@(posedge i_clk) disable iff (i_reset)
        i_b_valid |-> 32'(i_b_addr) < NUM_REGS);
    rd_addr_legal: assert property (@(posedge i_clk) disable iff (i_reset)
        32'(i_rd_addr_a) < NUM_REGS && 32'(i_rd_addr_b) < NUM_REGS &&
        32'(i_rd_addr_c) < NUM_REGS && 32'(i_rd_addr_d) < NUM_REGS);
    a_stable: assert property (@(posedge i_clk) disable iff (i_reset)
        (i_a_valid && !o_a_ready) |=> (i_a_valid && $stable(i_a_addr) && $stable(i_a_data)));
    b_stable: assert property (@(posedge i_clk) disable iff (i_reset)
        (i_b_valid && !o_b_ready) |=> (i_b_valid && $stable(i_b_addr) && $stable(i_b_data)));

endmodule

// File: tb/tb_zap_regf_write_queue.sv
// Scoreboard bench for zap_regf_write_queue: accepted writes are queued on the
// bench side and compared in order against what the DUT stages on its write ports.
module tb_zap_regf_write_queue;

    localparam int DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_a_valid, i_b_valid, i_hold;
    logic [5:0]  i_a_addr, i_b_addr;
    logic [31:0] i_a_data, i_b_data;
    logic [5:0]  i_rd_addr_a, i_rd_addr_b, i_rd_addr_c, i_rd_addr_d;
    logic        o_a_ready, o_b_ready, o_wen;
    logic [5:0]  o_wr_addr_a, o_wr_addr_b;
    logic [31:0] o_wr_data_a, o_wr_data_b;
    logic [3:0]  o_pending;
    logic [31:0] o_fwd_data_a, o_fwd_data_b, o_fwd_data_c, o_fwd_data_d;
    logic [2:0]  o_count;

    zap_regf_write_queue #(.DEPTH(4), .ADDR_W(6), .DATA_W(32), .NUM_REGS(40)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_a_valid(i_a_valid), .o_a_ready(o_a_ready), .i_a_addr(i_a_addr), .i_a_data(i_a_data),
        .i_b_valid(i_b_valid), .o_b_ready(o_b_ready), .i_b_addr(i_b_addr), .i_b_data(i_b_data),
        .i_hold(i_hold), .o_wen(o_wen),
        .o_wr_addr_a(o_wr_addr_a), .o_wr_addr_b(o_wr_addr_b),
        .o_wr_data_a(o_wr_data_a), .o_wr_data_b(o_wr_data_b),
        .i_rd_addr_a(i_rd_addr_a), .i_rd_addr_b(i_rd_addr_b),
        .i_rd_addr_c(i_rd_addr_c), .i_rd_addr_d(i_rd_addr_d),
        .o_pending(o_pending),
        .o_fwd_data_a(o_fwd_data_a), .o_fwd_data_b(o_fwd_data_b),
        .o_fwd_data_c(o_fwd_data_c), .o_fwd_data_d(o_fwd_data_d),
        .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t mq[$];          // accepted, not yet drained (front = oldest)
    wr_t st_a, st_b;     // pair expected on the write ports
    bit  st_v;
    bit  last_acc_a, last_acc_b;
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd_of(input int k);
        case (k)
            0: return o_fwd_data_a;
            1: return o_fwd_data_b;
            2: return o_fwd_data_c;
            default: return o_fwd_data_d;
        endcase
    endfunction

    function automatic logic [5:0] rd_of(input int k);
        case (k)
            0: return i_rd_addr_a;
            1: return i_rd_addr_b;
            2: return i_rd_addr_c;
            default: return i_rd_addr_d;
        endcase
    endfunction

    // Reference lookup: staged a, staged b, then queue oldest..youngest; last hit wins.
    task automatic ref_lookup(input logic [5:0] ra, output bit p, output logic [31:0] d);
        p = 0;
        d = '0;
        if (st_v && st_a.addr == ra) begin p = 1; d = st_a.data; end
        if (st_v && st_b.addr == ra) begin p = 1; d = st_b.data; end
        foreach (mq[i]) if (mq[i].addr == ra) begin p = 1; d = mq[i].data; end
    endtask

    // One clock with the currently driven inputs; checks before and after the edge.
    task automatic step();
        int   mc, n;
        bit   acc_a, acc_b, rst, p;
        logic [31:0] d;
        wr_t  wa, wb;
        #1;
        mc  = mq.size();
        rst = i_reset;
        if (!rst) begin
            chk("a_ready", o_a_ready, (DEPTH - mc) >= 1);
            chk("b_ready", o_b_ready, (DEPTH - mc) >= (i_a_valid ? 2 : 1));
            for (int k = 0; k < 4; k++) begin
                ref_lookup(rd_of(k), p, d);
                chk($sformatf("pending%0d", k), o_pending[k], p);
                chk($sformatf("fwd%0d", k), fwd_of(k), d);
            end
        end
        acc_a = i_a_valid && (DEPTH - mc) >= 1;
        acc_b = i_b_valid && (DEPTH - mc) >= (i_a_valid ? 2 : 1);
        n     = i_hold ? 0 : (mc > 2 ? 2 : mc);
        wa    = '{i_a_addr, i_a_data};
        wb    = '{i_b_addr, i_b_data};
        @(posedge i_clk);
        #1;
        if (rst) begin
            mq.delete();
            st_v = 0;
            st_a = '0;
            st_b = '0;
            last_acc_a = 0;
            last_acc_b = 0;
        end else begin
            if (n > 0) begin
                st_a = mq.pop_front();
                if (n == 2) st_b = mq.pop_front();
                else        st_b = st_a;
                st_v = 1;
            end else begin
                st_v = 0;
            end
            if (acc_a) mq.push_back(wa);
            if (acc_b) mq.push_back(wb);
            last_acc_a = acc_a;
            last_acc_b = acc_b;
        end
        chk("wen", o_wen, st_v);
        chk("wr_addr_a", o_wr_addr_a, st_a.addr);
        chk("wr_data_a", o_wr_data_a, st_a.data);
        chk("wr_addr_b", o_wr_addr_b, st_b.addr);
        chk("wr_data_b", o_wr_data_b, st_b.data);
        chk("count", o_count, mq.size());
    endtask

    task automatic idle_inputs();
        i_a_valid = 0; i_b_valid = 0;
        i_a_addr = 0; i_a_data = 0; i_b_addr = 0; i_b_data = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        i_reset = 1; i_hold = 0;
        idle_inputs();
        i_rd_addr_a = 0; i_rd_addr_b = 0; i_rd_addr_c = 0; i_rd_addr_d = 0;
        step(); step();
        i_reset = 0;
        #1;
        chk("rst_wen", o_wen, 0);
        chk("rst_count", o_count, 0);
        chk("rst_pending", o_pending, 0);

        // Single A write r3=0x11
        i_rd_addr_b = 3;
        i_a_valid = 1; i_a_addr = 3; i_a_data = 32'h11;
        step();
        idle_inputs();
        step();
        chk("t1_wen", o_wen, 1);
        chk("t1_addr_a", o_wr_addr_a, 3);
        chk("t1_addr_b", o_wr_addr_b, 3);
        chk("t1_data_b", o_wr_data_b, 32'h11);
        step();
        chk("t1_count", o_count, 0);

        // A and B to r5 in the same cycle
        i_rd_addr_a = 5;
        i_a_valid = 1; i_a_addr = 5; i_a_data = 32'hAA;
        i_b_valid = 1; i_b_addr = 5; i_b_data = 32'hBB;
        step();
        idle_inputs();
        #1;
        chk("t2_pend", o_pending[0], 1);
        chk("t2_fwd", o_fwd_data_a, 32'hBB);
        step();
        chk("t2_wen", o_wen, 1);
        chk("t2_data_a", o_wr_data_a, 32'hAA);
        chk("t2_data_b", o_wr_data_b, 32'hBB);
        step();

        // Fill under hold, then drain 4 -> 2 -> 0
        i_hold = 1;
        for (int i = 0; i < 4; i++) begin
            i_a_valid = 1; i_a_addr = 6'(10 + i); i_a_data = 32'h100 + i;
            step();
        end
        idle_inputs();
        #1;
        chk("t3_count", o_count, 4);
        chk("t3_a_ready", o_a_ready, 0);
        chk("t3_b_ready", o_b_ready, 0);
        i_hold = 0;
        step();
        chk("t4_count2", o_count, 2);
        chk("t4_first_a", o_wr_data_a, 32'h100);
        step();
        chk("t4_count0", o_count, 0);
        chk("t4_second_b", o_wr_data_b, 32'h103);
        step();

        // Full queue, hold released, A+B both valid: neither accepted that cycle
        i_hold = 1;
        for (int i = 0; i < 4; i++) begin
            i_a_valid = 1; i_a_addr = 6'(20 + i); i_a_data = 32'h200 + i;
            step();
        end
        i_a_valid = 1; i_a_addr = 30; i_a_data = 32'h300;
        i_b_valid = 1; i_b_addr = 31; i_b_data = 32'h301;
        step();
        i_hold = 0;
        #1;
        chk("t5_a_ready", o_a_ready, 0);
        chk("t5_b_ready", o_b_ready, 0);
        step();
        chk("t5_count", o_count, 2);
        step();
        chk("t5_count_acc", o_count, 2);
        idle_inputs();
        repeat (3) step();

        // Reset with 3 entries queued
        i_hold = 1;
        for (int i = 0; i < 3; i++) begin
            i_a_valid = 1; i_a_addr = 6'(1 + i); i_a_data = 32'h400 + i;
            step();
        end
        idle_inputs();
        i_rd_addr_c = 1;
        i_reset = 1;
        step();
        i_reset = 0;
        i_hold = 0;
        #1;
        chk("t6_wen", o_wen, 0);
        chk("t6_count", o_count, 0);
        chk("t6_pending", o_pending, 0);
        repeat (2) step();

        // r7 queued twice
        i_hold = 1;
        i_rd_addr_a = 7;
        i_a_valid = 1; i_a_addr = 7; i_a_data = 32'h1;
        step();
        i_a_data = 32'h2;
        step();
        idle_inputs();
        #1;
        chk("t7_pend", o_pending[0], 1);
        chk("t7_fwd", o_fwd_data_a, 32'h2);
        i_hold = 0;
        step();
        chk("t7_pend_staged", o_pending[0], 1);
        step();
        chk("t7_pend_done", o_pending[0], 0);
        chk("t7_fwd_done", o_fwd_data_a, 0);

        // Random traffic; a stalled source keeps its request stable
        for (int c = 0; c < 400; c++) begin
            if (!(i_a_valid && !last_acc_a)) begin
                i_a_valid = ($urandom_range(0, 9) < 6);
                i_a_addr  = 6'($urandom_range(0, 9));
                i_a_data  = $urandom;
            end
            if (!(i_b_valid && !last_acc_b)) begin
                i_b_valid = ($urandom_range(0, 9) < 6);
                i_b_addr  = 6'($urandom_range(0, 9));
                i_b_data  = $urandom;
            end
            i_hold      = ($urandom_range(0, 3) == 0);
            i_rd_addr_a = 6'($urandom_range(0, 9));
            i_rd_addr_b = 6'($urandom_range(0, 9));
            i_rd_addr_c = 6'($urandom_range(0, 9));
            i_rd_addr_d = 6'($urandom_range(0, 39));
            step();
        end
        // Drain what is left; stalled requests must stay up until accepted
        i_hold = 0;
        for (int c = 0; c < 8; c++) begin
            if (last_acc_a) i_a_valid = 0;
            if (last_acc_b) i_b_valid = 0;
            step();
        end
        chk("final_count", o_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
